// File: rtl/control_unit_pkg.sv
// control_unit_pkg
//   Shared definitions for the multicycle sequencer and its neighbours:
//   - instruction field positions,
//   - opcode values,
//   - ALU operation codes (the ALU decodes the same values),
//   - the sequencer state encoding,
//   - small opcode-class helpers.
package control_unit_pkg;

  // Instruction register field positions
  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RX_HI = 11;
  localparam int RX_LO = 9;
  localparam int RY_HI = 8;
  localparam int RY_LO = 6;

  // Opcodes. 0010..0111 are ALU operations; 1011..1111 execute as NOP.
  localparam logic [3:0] OP_MV   = 4'b0000;
  localparam logic [3:0] OP_MVI  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b1000;
  localparam logic [3:0] OP_SD   = 4'b1001;
  localparam logic [3:0] OP_MVNZ = 4'b1010;

  // ALU operation codes. An ALU instruction's alu_op equals op[2:0].
  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLL  = 3'b110;
  localparam logic [2:0] ALU_SRL  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_F_ADDR = 3'd1,
    S_F_WAIT = 3'd2,
    S_F_LOAD = 3'd3,
    S_EX1    = 3'd4,
    S_EX2    = 3'd5,
    S_EX3    = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  // True for opcodes 0010..0111.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op[3] == 1'b0) && (op[2:1] != 2'b00);
  endfunction

  // Instructions that spend EX2 waiting for a memory word (mvi, ld).
  function automatic logic is_mem_wait_op(input logic [3:0] op);
    return (op == OP_MVI) || (op == OP_LD);
  endfunction

endpackage

// File: rtl/control_unit_ctrl_decode.sv
// ctrl_decode
//   Purely combinational strobe decoder. It turns the sequencer state, the
//   latched instruction and the G==0 flag into the datapath strobes for the
//   current cycle.
//
//   Inputs:
//     state      - current sequencer state (state_t encoding)
//     ir         - latched instruction
//     g_zero     - G == 0 flag
//     first_wait - high on the first cycle of a memory wait
//   Outputs:
//     r_out, r_in                          - one-hot register bus / load enables
//     a_in, g_in, g_out, din_out           - A load, G load, G->bus, din->bus
//     addr_in, dout_in, w_d, incr_pc       - memory interface and PC increment
//     alu_op                               - ALU operation
//     done                                 - instruction-retire pulse
//
//   Every cycle has at most one bus driver (r_out, g_out or din_out).
module ctrl_decode
  import control_unit_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic [2:0]        state,
  input  logic [DATA_W-1:0] ir,
  input  logic              g_zero,
  input  logic              first_wait,
  output logic [NREGS-1:0]  r_out,
  output logic [NREGS-1:0]  r_in,
  output logic              a_in,
  output logic              g_in,
  output logic              g_out,
  output logic              din_out,
  output logic              addr_in,
  output logic              dout_in,
  output logic              w_d,
  output logic              incr_pc,
  output logic [2:0]        alu_op,
  output logic              done
);

  localparam logic [2:0] PC_IDX = 3'(NREGS - 1);

  state_t     st;
  logic [3:0] op;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       unused_ir;

  assign st = state_t'(state);
  assign op = ir[OP_HI:OP_LO];
  assign rx = ir[RX_HI:RX_LO];
  assign ry = ir[RY_HI:RY_LO];

  // The low IR bits carry no meaning for this instruction set.
  assign unused_ir = ^ir[RY_LO-1:0];

  function automatic logic [NREGS-1:0] sel(input logic [2:0] idx);
    logic [NREGS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  always_comb begin
    r_out   = '0;
    r_in    = '0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    g_out   = 1'b0;
    din_out = 1'b0;
    addr_in = 1'b0;
    dout_in = 1'b0;
    w_d     = 1'b0;
    incr_pc = 1'b0;
    alu_op  = ALU_NONE;
    done    = 1'b0;
    case (st)
      S_F_ADDR: begin
        r_out   = sel(PC_IDX);
        addr_in = 1'b1;
      end
      // The PC advances once per fetch, however long the memory wait is.
      S_F_WAIT: incr_pc = first_wait;
      S_EX1: begin
        if (op == OP_MV) begin
          r_out = sel(ry);
          r_in  = sel(rx);
        end else if (op == OP_MVI) begin
          r_out   = sel(PC_IDX);
          addr_in = 1'b1;
        end else if (is_alu_op(op)) begin
          r_out = sel(rx);
          a_in  = 1'b1;
        end else if ((op == OP_LD) || (op == OP_SD)) begin
          r_out   = sel(ry);
          addr_in = 1'b1;
        end else if ((op == OP_MVNZ) && !g_zero) begin
          r_out = sel(ry);
          r_in  = sel(rx);
        end
      end
      S_EX2: begin
        if (op == OP_MVI) begin
          // Step past the immediate word.
          incr_pc = first_wait;
        end else if (is_alu_op(op)) begin
          r_out  = sel(ry);
          g_in   = 1'b1;
          alu_op = op[2:0];
        end else if (op == OP_SD) begin
          r_out   = sel(rx);
          dout_in = 1'b1;
          w_d     = 1'b1;
        end
      end
      S_EX3: begin
        if (is_mem_wait_op(op)) begin
          din_out = 1'b1;
          r_in    = sel(rx);
        end else if (is_alu_op(op)) begin
          g_out = 1'b1;
          r_in  = sel(rx);
        end
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit
//   Multicycle sequencer for the 16-bit bus processor. It fetches through the
//   PC (the highest-numbered register), latches the instruction into IR and
//   steps through the execute cycles. The per-cycle strobes come from
//   ctrl_decode.
//
//   Ports:
//     clock, reset  - clock and synchronous active-high reset
//     run           - start/continue; looked at only in IDLE and DONE
//     din           - memory read data
//     g_zero        - G == 0 flag (used by mvnz)
//     r_out, r_in, a_in, g_in, g_out, din_out,
//     addr_in, dout_in, w_d, incr_pc, alu_op, done
//                   - datapath strobes (see ctrl_decode)
module control_unit
  import control_unit_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NREGS    = 8,
  parameter int MEM_WAIT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [DATA_W-1:0] din,
  input  logic              g_zero,
  output logic [NREGS-1:0]  r_out,
  output logic [NREGS-1:0]  r_in,
  output logic              a_in,
  output logic              g_in,
  output logic              g_out,
  output logic              din_out,
  output logic              addr_in,
  output logic              dout_in,
  output logic              w_d,
  output logic              incr_pc,
  output logic [2:0]        alu_op,
  output logic              done
);

  localparam int WCW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

  state_t            state_reg;
  state_t            state_next;
  logic [DATA_W-1:0] ir_reg;
  logic [WCW-1:0]    wait_cnt_reg;
  logic [WCW-1:0]    wait_cnt_next;
  logic [3:0]        op;
  logic              in_wait;
  logic              wait_last;
  logic              first_wait;

  assign op         = ir_reg[OP_HI:OP_LO];
  assign wait_last  = (wait_cnt_reg == WCW'(MEM_WAIT - 1));
  assign first_wait = (wait_cnt_reg == '0);
  assign in_wait    = (state_reg == S_F_WAIT) ||
                      ((state_reg == S_EX2) && is_mem_wait_op(op));

  // The counter runs only inside a wait state and is cleared on leaving it.
  assign wait_cnt_next = (in_wait && !wait_last) ? wait_cnt_reg + 1'b1 : '0;

  // State register, IR and wait counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      ir_reg       <= '0;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (state_reg == S_F_LOAD) begin
        ir_reg <= din;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   state_next = run ? S_F_ADDR : S_IDLE;
      S_F_ADDR: state_next = S_F_WAIT;
      S_F_WAIT: state_next = wait_last ? S_F_LOAD : S_F_WAIT;
      S_F_LOAD: state_next = S_EX1;
      S_EX1: begin
        // mv, mvnz and NOPs finish in one execute cycle.
        if (is_mem_wait_op(op) || is_alu_op(op) || (op == OP_SD)) begin
          state_next = S_EX2;
        end else begin
          state_next = S_DONE;
        end
      end
      S_EX2: begin
        if (op == OP_SD) begin
          state_next = S_DONE;
        end else if (is_mem_wait_op(op)) begin
          state_next = wait_last ? S_EX3 : S_EX2;
        end else begin
          state_next = S_EX3;
        end
      end
      S_EX3:   state_next = S_DONE;
      S_DONE:  state_next = run ? S_F_ADDR : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic.
  ctrl_decode #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_decode (
    .state      (state_reg),
    .ir         (ir_reg),
    .g_zero     (g_zero),
    .first_wait (first_wait),
    .r_out      (r_out),
    .r_in       (r_in),
    .a_in       (a_in),
    .g_in       (g_in),
    .g_out      (g_out),
    .din_out    (din_out),
    .addr_in    (addr_in),
    .dout_in    (dout_in),
    .w_d        (w_d),
    .incr_pc    (incr_pc),
    .alu_op     (alu_op),
    .done       (done)
  );

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
//   Directed bench for control_unit with the default parameters
//   (DATA_W=16, NREGS=8, MEM_WAIT=1). All outputs are packed into one vector
//   and compared on every falling edge against hand-built expected strobes.
module tb_control_unit;
  import control_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] din;
  logic        g_zero;
  logic [7:0]  r_out;
  logic [7:0]  r_in;
  logic        a_in, g_in, g_out, din_out;
  logic        addr_in, dout_in, w_d, incr_pc;
  logic [2:0]  alu_op;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  control_unit dut (
    .clock   (clock),
    .reset   (reset),
    .run     (run),
    .din     (din),
    .g_zero  (g_zero),
    .r_out   (r_out),
    .r_in    (r_in),
    .a_in    (a_in),
    .g_in    (g_in),
    .g_out   (g_out),
    .din_out (din_out),
    .addr_in (addr_in),
    .dout_in (dout_in),
    .w_d     (w_d),
    .incr_pc (incr_pc),
    .alu_op  (alu_op),
    .done    (done)
  );

  // Output vector: {r_out, r_in, flags, alu_op, done}
  logic [27:0] outs;
  assign outs = {r_out, r_in, a_in, g_in, g_out, din_out,
                 addr_in, dout_in, w_d, incr_pc, alu_op, done};

  localparam logic [7:0] A_IN    = 8'h80;
  localparam logic [7:0] G_IN    = 8'h40;
  localparam logic [7:0] G_OUT   = 8'h20;
  localparam logic [7:0] DIN_OUT = 8'h10;
  localparam logic [7:0] ADDR_IN = 8'h08;
  localparam logic [7:0] DOUT_IN = 8'h04;
  localparam logic [7:0] W_D     = 8'h02;
  localparam logic [7:0] INCR    = 8'h01;
  localparam logic [7:0] NO8     = 8'h00;
  localparam logic [2:0] NOOP    = 3'b000;
  localparam logic [27:0] ZERO   = 28'h0;
  localparam logic [27:0] DONE_V = 28'h1;

  function automatic logic [27:0] mk(input logic [7:0] ro, input logic [7:0] ri,
                                     input logic [7:0] fl, input logic [2:0] aop);
    return {ro, ri, fl, aop, 1'b0};
  endfunction

  // Advance to the next falling edge and compare all outputs.
  task automatic cyc(input string tag, input logic [27:0] exp);
    @(negedge clock);
    n_checks++;
    assert (outs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, outs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [2:0] exp);
    n_checks++;
    assert (3'(dut.state_reg) === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, 3'(dut.state_reg), exp);
    end
  endtask

  // Called at a falling edge in IDLE or DONE; covers the three fetch cycles.
  task automatic fetch(input logic [15:0] instr, input string tag);
    din = instr;
    run = 1'b1;
    cyc($sformatf("%s.f_addr", tag), mk(8'h80, NO8, ADDR_IN, NOOP));
    run = 1'b0;
    cyc($sformatf("%s.f_wait", tag), mk(NO8, NO8, INCR, NOOP));
    cyc($sformatf("%s.f_load", tag), ZERO);
  endtask

  initial begin
    reset  = 1'b1;
    run    = 1'b0;
    din    = 16'h0000;
    g_zero = 1'b0;

    // 1: reset for two cycles, then IDLE with run low
    repeat (2) @(posedge clock);
    cyc("reset.outs", ZERO);
    chk_state("reset.state", 3'(S_IDLE));
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc($sformatf("idle%0d.outs", i), ZERO);
      chk_state($sformatf("idle%0d.state", i), 3'(S_IDLE));
    end
    $display("txn reset/idle checked");

    // 2: add R1,R2
    fetch(16'h2280, "add");
    cyc("add.ex1", mk(8'h02, NO8, A_IN, NOOP));
    cyc("add.ex2", mk(8'h04, NO8, G_IN, 3'b010));
    cyc("add.ex3", mk(NO8, 8'h02, G_OUT, NOOP));
    cyc("add.done", DONE_V);
    $display("txn add R1,R2 retired");
    cyc("add.idle", ZERO);

    // 3: mvi R3,#0x00AB
    fetch(16'h1600, "mvi");
    cyc("mvi.ex1", mk(8'h80, NO8, ADDR_IN, NOOP));
    din = 16'h00AB;
    cyc("mvi.ex2", mk(NO8, NO8, INCR, NOOP));
    cyc("mvi.ex3", mk(NO8, 8'h08, DIN_OUT, NOOP));
    cyc("mvi.done", DONE_V);
    $display("txn mvi R3 retired");
    cyc("mvi.idle", ZERO);

    // 4: mvnz R0,R1 taken, then not taken
    g_zero = 1'b0;
    fetch(16'hA040, "mvnz_t");
    cyc("mvnz_t.ex1", mk(8'h02, 8'h01, NO8, NOOP));
    cyc("mvnz_t.done", DONE_V);
    $display("txn mvnz R0,R1 (g_zero=0) retired");
    g_zero = 1'b1;
    fetch(16'hA040, "mvnz_n");
    cyc("mvnz_n.ex1", ZERO);
    cyc("mvnz_n.done", DONE_V);
    $display("txn mvnz R0,R1 (g_zero=1) retired");
    g_zero = 1'b0;
    cyc("mvnz.idle", ZERO);

    // 5: sd R4,(R5), then ld R6,(R5) fetched straight from DONE
    fetch(16'h9940, "sd");
    cyc("sd.ex1", mk(8'h20, NO8, ADDR_IN, NOOP));
    cyc("sd.ex2", mk(8'h10, NO8, DOUT_IN | W_D, NOOP));
    cyc("sd.done", DONE_V);
    $display("txn sd R4,(R5) retired");
    fetch(16'h8D40, "ld");
    cyc("ld.ex1", mk(8'h20, NO8, ADDR_IN, NOOP));
    din = 16'h1234;
    cyc("ld.ex2", ZERO);
    cyc("ld.ex3", mk(NO8, 8'h40, DIN_OUT, NOOP));
    cyc("ld.done", DONE_V);
    $display("txn ld R6,(R5) retired");
    cyc("ld.idle", ZERO);

    // 6: reset during ALU EX2 aborts the sub
    fetch(16'h3280, "sub");
    cyc("sub.ex1", mk(8'h02, NO8, A_IN, NOOP));
    cyc("sub.ex2", mk(8'h04, NO8, G_IN, 3'b011));
    reset = 1'b1;
    cyc("sub.abort", ZERO);
    chk_state("sub.abort.state", 3'(S_IDLE));
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("abort.idle%0d", i), ZERO);
    end
    $display("txn sub R1,R2 aborted by reset");

    // Opcode 1111 executes as a NOP
    fetch(16'hF000, "nop");
    cyc("nop.ex1", ZERO);
    cyc("nop.done", DONE_V);
    $display("txn nop retired");
    cyc("nop.idle", ZERO);
    chk_state("end.state", 3'(S_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
